// File: rtl/run_sequencer.sv
// run_sequencer: starts the CPU at a program address, counts cycles until it halts, then streams a window of data memory out.
// The optional RUN-state watchdog is enabled by defining RUN_TIMEOUT_EN.
module run_sequencer #(
    parameter int ADDR_WIDTH     = 8,
    parameter int DATA_WIDTH     = 8,
    parameter int START_CYCLES   = 2,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                  f_clk,
    input  logic                  reset,
    input  logic                  go,
    input  logic [ADDR_WIDTH-1:0] prog_addr,
    input  logic [ADDR_WIDTH-1:0] dump_base,
    input  logic [ADDR_WIDTH-1:0] dump_len,
    output logic                  busy,
    output logic                  start,
    output logic [ADDR_WIDTH-1:0] start_addr,
    input  logic                  halt_i,
    output logic                  mem_rd,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_q,
    output logic                  dout_valid,
    input  logic                  dout_ready,
    output logic [DATA_WIDTH-1:0] dout_data,
    output logic [ADDR_WIDTH-1:0] dout_addr,
    output logic                  dout_last,
    output logic                  done,
    output logic                  timeout,
    output logic [15:0]           cycle_count
);
`ifdef RUN_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif
    localparam int SW = $clog2(START_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, START, RUN, DUMP_RD, DUMP_WAIT, DUMP_OUT, DONE} state_t;

    state_t                state, state_nxt;
    logic [SW-1:0]         start_cnt;
    logic [ADDR_WIDTH-1:0] base, len, idx;
    logic                  is_last, start_end, timeout_hit;

    assign is_last     = idx == ADDR_WIDTH'(len - 1'b1);
    assign start_end   = start_cnt == SW'(START_CYCLES - 1);
    assign timeout_hit = TO_EN && cycle_count == 16'(TIMEOUT_CYCLES - 1);
    assign busy        = state != IDLE;
    assign start       = state == START;
    assign mem_rd      = state == DUMP_RD;
    assign mem_addr    = base + idx;
    assign dout_valid  = state == DUMP_OUT;
    assign dout_last   = dout_valid && is_last;
    assign done        = state == DONE;

    // next-state selection
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      state_nxt = go ? START : IDLE;
            START:     state_nxt = start_end ? RUN : START;
            RUN:       state_nxt = halt_i ? (len == '0 ? DONE : DUMP_RD) : (timeout_hit ? DONE : RUN);
            DUMP_RD:   state_nxt = DUMP_WAIT;
            DUMP_WAIT: state_nxt = DUMP_OUT;
            DUMP_OUT:  state_nxt = dout_ready ? (is_last ? DONE : DUMP_RD) : DUMP_OUT;
            DONE:      state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    // state register
    always_ff @(posedge f_clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // captured run parameters, cycle counter, dump index and output word registers
    always_ff @(posedge f_clk) begin
        if (reset) begin
            start_cnt   <= '0;
            start_addr  <= '0;
            base        <= '0;
            len         <= '0;
            idx         <= '0;
            cycle_count <= '0;
            timeout     <= 1'b0;
            dout_data   <= '0;
            dout_addr   <= '0;
        end else begin
            if (state == IDLE && go) begin
                start_addr  <= prog_addr;
                base        <= dump_base;
                len         <= dump_len;
                idx         <= '0;
                start_cnt   <= '0;
                cycle_count <= '0;
                timeout     <= 1'b0;
            end
            if (state == START) start_cnt <= start_cnt + 1'b1;
            if (state == RUN && !halt_i) begin
                if (cycle_count != 16'hFFFF) cycle_count <= cycle_count + 16'd1;
                if (timeout_hit) timeout <= 1'b1;
            end
            if (state == DUMP_WAIT) begin
                dout_data <= mem_q;
                dout_addr <= mem_addr;
            end
            if (state == DUMP_OUT && dout_ready) idx <= idx + 1'b1;
        end
    end
endmodule

// File: tb/tb_run_sequencer.sv
// tb_run_sequencer: randomized run/dump sequences checked against a transaction-level model of the run sequencer.
module tb_run_sequencer;
    localparam int SC = 2;
    localparam int TO = 16;
`ifdef RUN_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        f_clk, reset, go, halt_i, dout_ready;
    logic [7:0]  prog_addr, dump_base, dump_len, mem_q;
    logic        busy, start, mem_rd, dout_valid, dout_last, done, timeout;
    logic [7:0]  start_addr, mem_addr, dout_data, dout_addr;
    logic [15:0] cycle_count;
    logic [7:0]  ram [256];
    int          n_vec = 0, n_err = 0;

    run_sequencer #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .START_CYCLES(SC), .TIMEOUT_CYCLES(TO)) dut (
        .f_clk(f_clk), .reset(reset), .go(go), .prog_addr(prog_addr), .dump_base(dump_base),
        .dump_len(dump_len), .busy(busy), .start(start), .start_addr(start_addr), .halt_i(halt_i),
        .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_q(mem_q), .dout_valid(dout_valid),
        .dout_ready(dout_ready), .dout_data(dout_data), .dout_addr(dout_addr), .dout_last(dout_last),
        .done(done), .timeout(timeout), .cycle_count(cycle_count)
    );

    initial f_clk = 1'b0;
    always #5 f_clk = ~f_clk;

    // one-cycle read latency data memory
    always @(posedge f_clk) if (mem_rd) mem_q <= ram[mem_addr];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge f_clk);
        #1;
    endtask

    // One complete run: expected start count, cycle count, dumped words and done pulse come from the run parameters.
    task automatic run(input logic [7:0] prog, input logic [7:0] base, input logic [7:0] len,
                       input int n_halt, input int rmode, input int abort_word);
        int   starts, run_cyc, words, rds, stall, exp_cc, exp_words;
        bit   halted, timed;
        logic [7:0] ea;
        starts = 0; run_cyc = 0; words = 0; rds = 0; stall = 0; halted = 0;
        timed     = TO_EN && n_halt >= TO;
        exp_cc    = timed ? TO : n_halt;
        exp_words = timed ? 0 : int'(len);
        go = 1; prog_addr = prog; dump_base = base; dump_len = len; halt_i = 0; dout_ready = 0;
        tick();
        check("busy_after_go", busy, 1);
        for (int k = 0; k < 3000; k++) begin
            check("busy_in_run", busy, 1);
            go = 1'($urandom_range(0, 1)); prog_addr = 8'($urandom); dump_base = 8'($urandom); dump_len = 8'($urandom);
            halt_i = 0;
            if (start) begin
                starts++;
                check("start_addr", start_addr, prog);
                halt_i = 1'($urandom_range(0, 1));
            end else if (!done && !halted && !mem_rd && !dout_valid) begin
                run_cyc++;
                if (run_cyc == n_halt + 1) begin
                    halted = 1;
                    halt_i = 1;
                end
            end
            if (mem_rd) begin
                ea = base + 8'(rds);
                check("mem_addr", mem_addr, ea);
                rds++;
            end
            if (dout_valid) begin
                ea = base + 8'(words);
                check("dout_addr", dout_addr, ea);
                check("dout_data", dout_data, ram[ea]);
                check("dout_last", dout_last, words == int'(len) - 1);
                if (abort_word == words) begin
                    go = 0; reset = 1;
                    tick();
                    check("abort_valid", dout_valid, 0);
                    check("abort_busy", busy, 0);
                    check("abort_start", start, 0);
                    check("abort_done", done, 0);
                    reset = 0;
                    tick();
                    return;
                end
                dout_ready = rmode == 0 ? 1'b1 : rmode == 1 ? 1'($urandom_range(0, 1)) : 1'(stall >= 5);
                if (dout_ready) begin
                    words++;
                    stall = 0;
                end else stall++;
            end else begin
                check("last_low", dout_last, 0);
                dout_ready = 1'($urandom_range(0, 1));
            end
            if (done) begin
                check("cycle_count", cycle_count, exp_cc);
                check("timeout", timeout, timed);
                check("words", words, exp_words);
                check("mem_rd_pulses", rds, exp_words);
                check("start_cycles", starts, SC);
                go = 1;
                tick();
                check("go_in_done_ignored", busy, 0);
                check("done_pulse", done, 0);
                go = 0;
                tick();
                check("idle_busy", busy, 0);
                return;
            end
            tick();
        end
        check("run_finished", 0, 1);
    endtask

    initial begin
        reset = 1; go = 1; halt_i = 0; dout_ready = 0; mem_q = 0;
        prog_addr = 8'h33; dump_base = 8'h44; dump_len = 8'h05;
        for (int i = 0; i < 256; i++) ram[i] = 8'($urandom);
        tick();
        tick();
        check("rst_busy", busy, 0);
        check("rst_start", start, 0);
        check("rst_mem_rd", mem_rd, 0);
        check("rst_valid", dout_valid, 0);
        check("rst_last", dout_last, 0);
        check("rst_done", done, 0);
        check("rst_timeout", timeout, 0);
        check("rst_start_addr", start_addr, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_dout_data", dout_data, 0);
        check("rst_dout_addr", dout_addr, 0);
        check("rst_cycle_count", cycle_count, 0);
        reset = 0; go = 0;
        tick();
        check("idle_after_rst", busy, 0);
        run(8'h5E, 8'h00, 8'd0, 40, 0, -1);
        ram[8'h10] = 8'hAA; ram[8'h11] = 8'hBB; ram[8'h12] = 8'hCC;
        run(8'($urandom), 8'h10, 8'd3, 7, 0, -1);
        run(8'($urandom), 8'hFE, 8'd3, 5, 2, -1);
        run(8'($urandom), 8'h33, 8'd4, TO + 4, 1, -1);
        run(8'($urandom), 8'h40, 8'd4, 7, 1, 1);
        run(8'($urandom), 8'h50, 8'd2, 3, 0, -1);
        for (int r = 0; r < 12; r++)
            run(8'($urandom), 8'($urandom), 8'($urandom_range(0, 6)), int'($urandom_range(0, 30)),
                int'($urandom_range(0, 2)), -1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
